// File: rtl/fader_axis_tx.sv
// Packs fader dv/chan samples into NCHAN-beat AXI4-Stream frames with tlast; first beat 2 cycles after a frame's last sample.
// Backpressure: whole frames wait in a DEPTH-entry FIFO and are dropped when the FIFO lacks room. The FADER_AXIS_TX_CFG_EN macro enables the config FSM.
module fader_axis_tx #(
    parameter int         NCHAN   = 32,
    parameter int         DW      = 16,
    parameter int         DEPTH   = 64,
    parameter logic [9:0] SCALE   = 10'b0101010110,
    parameter logic       FWD_INV = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dv_in,
    input  logic [$clog2(NCHAN)-1:0] chan_in,
    input  logic [DW-1:0]            din_real,
    input  logic [DW-1:0]            din_imag,
    output logic [15:0]              m_axis_config_tdata,
    output logic                     m_axis_config_tvalid,
    input  logic                     m_axis_config_tready,
    output logic [2*DW-1:0]          m_axis_data_tdata,
    output logic                     m_axis_data_tvalid,
    input  logic                     m_axis_data_tready,
    output logic                     m_axis_data_tlast,
    output logic [15:0]              frame_count,
    output logic                     overflow,
    output logic                     seq_err
);
    localparam int CW = $clog2(NCHAN);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ROOM_MAX  = PW'(DEPTH - NCHAN);
    localparam logic [CW-1:0] LAST_CHAN = CW'(NCHAN - 1);

    typedef enum logic { IN_IDLE, IN_COLLECT } in_state_t;

    logic [2*DW-1:0] mem [DEPTH];

    in_state_t       in_state_q, in_state_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   exp_chan_q, exp_chan_d;
    logic [PW-1:0]   wr_tmp_q, wr_tmp_d;
    logic [PW-1:0]   wr_cmt_q, wr_cmt_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            seq_err_q, seq_err_d;
    logic            out_vld_q, out_vld_d;
    logic [2*DW-1:0] out_dat_q, out_dat_d;
    logic            out_last_q, out_last_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [15:0]     frame_q, frame_d;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            sof;
    logic            load;
    logic            cfg_done;
    logic [PW-1:0]   used;

    assign m_axis_config_tdata = {5'd0, SCALE, FWD_INV};

`ifdef FADER_AXIS_TX_CFG_EN
    typedef enum logic { CFG_SEND, CFG_DONE } cfg_state_t;
    cfg_state_t cfg_state_q, cfg_state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_state_q <= CFG_SEND;
        end else begin
            cfg_state_q <= cfg_state_d;
        end
    end

    always_comb begin
        cfg_state_d          = cfg_state_q;
        m_axis_config_tvalid = 1'b0;
        cfg_done             = 1'b0;
        case (cfg_state_q)
            CFG_SEND: begin
                m_axis_config_tvalid = 1'b1;
                if (m_axis_config_tready) begin
                    cfg_state_d = CFG_DONE;
                end
            end
            default: cfg_done = 1'b1;
        endcase
    end
`else
    logic unused_cfg_tready;
    assign unused_cfg_tready    = m_axis_config_tready;
    assign m_axis_config_tvalid = 1'b0;
    assign cfg_done             = 1'b1;
`endif

    // Occupancy seen by a new frame: the uncommitted tail has always been rewound by then.
    assign used = wr_cmt_q - rd_ptr_q;

    always_comb begin
        in_state_d = in_state_q;
        drop_d     = drop_q;
        exp_chan_d = exp_chan_q;
        wr_tmp_d   = wr_tmp_q;
        wr_cmt_d   = wr_cmt_q;
        overflow_d = overflow_q;
        seq_err_d  = seq_err_q;
        wr_en      = 1'b0;
        wr_addr    = wr_tmp_q[AW-1:0];
        sof        = 1'b0;
        if (dv_in) begin
            case (in_state_q)
                IN_COLLECT: begin
                    if (chan_in == exp_chan_q) begin
                        wr_en      = 1'b1;
                        wr_tmp_d   = wr_tmp_q + 1'b1;
                        exp_chan_d = chan_in + 1'b1;
                        if (chan_in == LAST_CHAN) begin
                            wr_cmt_d   = wr_tmp_q + 1'b1;
                            in_state_d = IN_IDLE;
                        end
                    end else begin
                        seq_err_d  = 1'b1;
                        wr_tmp_d   = wr_cmt_q;
                        in_state_d = IN_IDLE;
                        sof        = (chan_in == '0);
                    end
                end
                default: begin
                    if (chan_in == '0) begin
                        sof = 1'b1;
                    end else if (!drop_q) begin
                        seq_err_d = 1'b1;
                    end
                end
            endcase
        end
        // A frame start is admitted only if the whole frame is guaranteed to fit.
        if (sof) begin
            if (used <= ROOM_MAX) begin
                wr_en      = 1'b1;
                wr_addr    = wr_cmt_q[AW-1:0];
                wr_tmp_d   = wr_cmt_q + 1'b1;
                exp_chan_d = CW'(1);
                drop_d     = 1'b0;
                in_state_d = IN_COLLECT;
            end else begin
                overflow_d = 1'b1;
                drop_d     = 1'b1;
                in_state_d = IN_IDLE;
            end
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        beat_d     = beat_q;
        frame_d    = frame_q;
        load       = (!out_vld_q || m_axis_data_tready) && (rd_ptr_q != wr_cmt_q) && cfg_done;
        if (out_vld_q && m_axis_data_tready) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            beat_d     = beat_q + 1'b1;
            if (out_last_q) begin
                frame_d = frame_q + 16'd1;
            end
        end
        if (load) begin
            out_vld_d  = 1'b1;
            out_dat_d  = mem[rd_ptr_q[AW-1:0]];
            out_last_d = (beat_d == LAST_CHAN);
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {din_imag, din_real};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_q <= IN_IDLE;
            drop_q     <= 1'b0;
            exp_chan_q <= '0;
            wr_tmp_q   <= '0;
            wr_cmt_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            beat_q     <= '0;
            frame_q    <= '0;
        end else begin
            in_state_q <= in_state_d;
            drop_q     <= drop_d;
            exp_chan_q <= exp_chan_d;
            wr_tmp_q   <= wr_tmp_d;
            wr_cmt_q   <= wr_cmt_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            beat_q     <= beat_d;
            frame_q    <= frame_d;
        end
    end

    assign m_axis_data_tdata  = out_dat_q;
    assign m_axis_data_tvalid = out_vld_q;
    assign m_axis_data_tlast  = out_last_q;
    assign frame_count        = frame_q;
    assign overflow           = overflow_q;
    assign seq_err            = seq_err_q;

endmodule
